// File: rtl/md_unit.sv
// Purpose: multiply/divide unit (mult/div/madd/msub, signed and unsigned) owning the architectural HI/LO pair.
// Latency: MULT_CYCLES or DIV_CYCLES edges from Start to HI/LO commit; mthi/mtlo take one edge.
// Backpressure: Busy is high while an operation is in flight; Start and We are dropped while Busy.
//
// Ports:
//   clk    - single clock, all state changes on its rising edge
//   reset  - synchronous, active-low; clears HI/LO and aborts a running operation
//   Start  - launch Op on A, B (accepted only when idle; wins over We)
//   Op     - 000 multu, 001 mult, 010 divu, 011 div, 100 maddu, 101 madd, 110 msubu, 111 msub
//   HiLo   - 0 selects HI, 1 selects LO for both We and Out
//   We     - write A into the selected HI/LO register (idle only)
//   A, B   - operands; A is also the mthi/mtlo write data
//   Busy   - operation in flight
//   Out    - committed HI or LO, combinational from registers and HiLo
module md_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Start,
    input  logic [2:0]       Op,
    input  logic             HiLo,
    input  logic             We,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic [WIDTH-1:0] Out
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [2:0]       op_q, op_d;

    // ------------------------------------------------------------------
    // Result datapath, driven only by the operands latched at Start
    // ------------------------------------------------------------------
    logic [2*WIDTH-1:0] prod_u;
    logic [2*WIDTH-1:0] prod_s;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mul_res;

    // The low 2*WIDTH bits of the product of sign-extended operands are
    // exactly the two's-complement signed product.
    assign prod_u = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
    assign prod_s = {{WIDTH{a_q[WIDTH-1]}}, a_q} * {{WIDTH{b_q[WIDTH-1]}}, b_q};
    assign prod   = op_q[0] ? prod_s : prod_u;
    assign acc    = {hi_q, lo_q};

    always_comb begin
        mul_res = prod;
        case (op_q[2:1])
            2'b10:   mul_res = acc + prod;
            2'b11:   mul_res = acc - prod;
            default: mul_res = prod;
        endcase
    end

    // Signed division runs on magnitudes through the same unsigned divider,
    // then the signs are reapplied: quotient negative when operand signs
    // differ, remainder follows the dividend. The most-negative / -1 case
    // falls out naturally: |A| is 2^(WIDTH-1) as an unsigned value, the
    // quotient keeps that bit pattern and the remainder is zero.
    logic             a_neg, b_neg, sgn;
    logic [WIDTH-1:0] dvd, dvs;
    logic [WIDTH-1:0] uq, ur;
    logic [WIDTH-1:0] div_q, div_r;

    assign sgn   = op_q[0];
    assign a_neg = sgn & a_q[WIDTH-1];
    assign b_neg = sgn & b_q[WIDTH-1];
    assign dvd   = a_neg ? (~a_q + 1'b1) : a_q;
    assign dvs   = b_neg ? (~b_q + 1'b1) : b_q;

    always_comb begin
        uq    = '0;
        ur    = '0;
        div_q = '0;
        div_r = '0;
        if (b_q == '0) begin
            // Divide by zero: defined result rather than whatever the divider yields.
            div_q = '1;
            div_r = a_q;
        end else begin
            uq    = dvd / dvs;
            ur    = dvd % dvs;
            div_q = (a_neg ^ b_neg) ? (~uq + 1'b1) : uq;
            div_r = a_neg ? (~ur + 1'b1) : ur;
        end
    end

    // ------------------------------------------------------------------
    // Control: next state
    // ------------------------------------------------------------------
    logic op_is_div;
    assign op_is_div = (Op[2:1] == 2'b01);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        case (state_q)
            IDLE: begin
                if (Start) begin
                    a_d     = A;
                    b_d     = B;
                    op_d    = Op;
                    cnt_d   = op_is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                    state_d = RUN;
                end else if (We) begin
                    if (HiLo) begin
                        lo_d = A;
                    end else begin
                        hi_d = A;
                    end
                end
            end
            RUN: begin
                cnt_d = cnt_q - 1'b1;
                // Commit on the last busy edge so Busy lasts exactly N cycles
                // and a new Start is accepted in the very next cycle.
                if (cnt_q == CW'(1)) begin
                    if (op_q[2:1] == 2'b01) begin
                        hi_d = div_r;
                        lo_d = div_q;
                    end else begin
                        {hi_d, lo_d} = mul_res;
                    end
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
        end
    end

    assign Busy = (state_q == RUN);
    assign Out  = HiLo ? lo_q : hi_q;

endmodule

// File: tb/tb_md_unit.sv
// Purpose: self-checking bench for md_unit at WIDTH=32 (5/10 cycles) and WIDTH=8 (1/3 cycles).
// Latency: a behavioural model predicts Busy and Out each cycle; literal checks pin key results.
// Backpressure: stimulus deliberately drives Start/We while Busy to exercise the drop behaviour.
module tb_md_unit;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        Start;
    logic        We;
    logic        HiLo;
    logic [2:0]  Op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy0, busy1;
    logic [31:0] out0;
    logic [7:0]  out1;

    md_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut0 (
        .clk(clk), .reset(reset), .Start(Start), .Op(Op), .HiLo(HiLo), .We(We),
        .A(A), .B(B), .Busy(busy0), .Out(out0)
    );

    md_unit #(.WIDTH(8), .MULT_CYCLES(1), .DIV_CYCLES(3)) dut1 (
        .clk(clk), .reset(reset), .Start(Start), .Op(Op), .HiLo(HiLo), .We(We),
        .A(A[7:0]), .B(B[7:0]), .Busy(busy1), .Out(out1)
    );

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] wm(input int w);
        return (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    endfunction

    // Architectural result {HI, LO} of an operation, from plain arithmetic.
    function automatic logic [63:0] ref_op(input int w, input logic [2:0] op,
                                           input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] hi, input logic [31:0] lo);
        logic [63:0] ua, ub, prod, acc, res, m2;
        longint      sa, sb, q, r, minv;
        logic [31:0] mw, rh, rl;
        mw   = wm(w);
        ua   = {32'b0, a & mw};
        ub   = {32'b0, b & mw};
        sa   = longint'(ua);
        sb   = longint'(ub);
        if (ua[w-1]) sa = sa - (longint'(1) << w);
        if (ub[w-1]) sb = sb - (longint'(1) << w);
        minv = -(longint'(1) << (w - 1));
        m2   = (w == 32) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (2 * w)) - 64'd1);
        rh   = '0;
        rl   = '0;
        if (op[2:1] == 2'b01) begin
            if (ub == 64'd0) begin
                rl = mw;
                rh = a & mw;
            end else if (!op[0]) begin
                rl = 32'(ua / ub);
                rh = 32'(ua % ub);
            end else if (sa == minv && sb == -1) begin
                rl = a & mw;
                rh = '0;
            end else begin
                q  = sa / sb;
                r  = sa % sb;
                rl = 32'(q) & mw;
                rh = 32'(r) & mw;
            end
        end else begin
            prod = op[0] ? 64'(sa * sb) : (ua * ub);
            acc  = ({32'b0, hi & mw} << w) | {32'b0, lo & mw};
            case (op[2:1])
                2'b00:   res = prod;
                2'b10:   res = acc + prod;
                default: res = acc - prod;
            endcase
            res = res & m2;
            rl  = 32'(res) & mw;
            rh  = 32'(res >> w) & mw;
        end
        return {rh, rl};
    endfunction

    // Behavioural model for both instances: index 0 is WIDTH=32, index 1 is WIDTH=8.
    int          m_w  [2] = '{32, 8};
    int          m_mc [2] = '{5, 1};
    int          m_dc [2] = '{10, 3};
    int          m_left[2] = '{0, 0};
    logic [31:0] m_hi [2];
    logic [31:0] m_lo [2];
    logic [31:0] m_a  [2];
    logic [31:0] m_b  [2];
    logic [2:0]  m_op [2];

    always @(posedge clk) begin
        logic [63:0] res;
        for (int i = 0; i < 2; i++) begin
            if (!reset) begin
                m_hi[i]   = '0;
                m_lo[i]   = '0;
                m_left[i] = 0;
            end else if (m_left[i] > 0) begin
                if (m_left[i] == 1) begin
                    res     = ref_op(m_w[i], m_op[i], m_a[i], m_b[i], m_hi[i], m_lo[i]);
                    m_hi[i] = res[63:32];
                    m_lo[i] = res[31:0];
                end
                m_left[i] = m_left[i] - 1;
            end else if (Start) begin
                m_op[i]   = Op;
                m_a[i]    = A & wm(m_w[i]);
                m_b[i]    = B & wm(m_w[i]);
                m_left[i] = (Op[2:1] == 2'b01) ? m_dc[i] : m_mc[i];
            end else if (We) begin
                if (HiLo) m_lo[i] = A & wm(m_w[i]);
                else      m_hi[i] = A & wm(m_w[i]);
            end
        end
    end

    // Per-cycle comparison, well clear of the rising edge and after input drive.
    always @(negedge clk) begin
        if (chk_en) begin
            #2;
            chk("busy0", busy0, m_left[0] > 0);
            chk("out0", out0, HiLo ? m_lo[0] : m_hi[0]);
            chk("busy1", busy1, m_left[1] > 0);
            chk("out1", out1, (HiLo ? m_lo[1] : m_hi[1]) & 32'hFF);
        end
    end

    task automatic run_op(input string name, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b, input int exp_n);
        int n;
        Op = op; A = a; B = b; Start = 1'b1; We = 1'b0;
        @(negedge clk);
        Start = 1'b0;
        n = 0;
        while (busy0 === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk({name, "_busy_cycles"}, n, exp_n);
    endtask

    task automatic check_out(input string name, input logic [31:0] hi_e, input logic [31:0] lo_e);
        HiLo = 1'b0;
        #1;
        chk({name, "_hi"}, out0, hi_e);
        HiLo = 1'b1;
        #1;
        chk({name, "_lo"}, out0, lo_e);
    endtask

    initial begin
        int n;
        reset = 1'b0; Start = 1'b0; We = 1'b0; HiLo = 1'b0; Op = '0; A = '0; B = '0;

        // Pin the model itself with hand-computed values.
        chk("model_mult", ref_op(32, 3'b001, 32'hFFFF_FFFD, 32'd7, 0, 0), {32'hFFFF_FFFF, 32'hFFFF_FFEB});
        chk("model_div", ref_op(32, 3'b011, 32'hFFFF_FFF9, 32'd2, 0, 0), {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        chk("model_w8", ref_op(8, 3'b001, 32'h80, 32'h80, 0, 0), {32'h40, 32'h00});
        chk("model_msubu", ref_op(32, 3'b110, 32'hFFFF_FFFF, 32'd1, 32'd1, 32'hFFFF_FFFF), {32'd1, 32'd0});

        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        reset  = 1'b1;
        check_out("reset", 32'h0, 32'h0);
        chk("reset_busy", busy0, 1'b0);
        @(negedge clk);

        run_op("mult", 3'b001, 32'hFFFF_FFFD, 32'd7, 5);
        check_out("mult", 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run_op("multu", 3'b000, 32'hFFFF_FFFF, 32'd2, 5);
        check_out("multu", 32'd1, 32'hFFFF_FFFE);
        run_op("madd", 3'b101, 32'd1, 32'd1, 5);
        check_out("madd", 32'd1, 32'hFFFF_FFFF);
        run_op("msubu", 3'b110, 32'hFFFF_FFFF, 32'd1, 5);
        check_out("msubu", 32'd1, 32'd0);
        run_op("div", 3'b011, 32'hFFFF_FFF9, 32'd2, 10);
        check_out("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu0", 3'b010, 32'd5, 32'd0, 10);
        check_out("divu0", 32'd5, 32'hFFFF_FFFF);
        run_op("divmin", 3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 10);
        check_out("divmin", 32'd0, 32'h8000_0000);

        // Start and We presented throughout a multu run must be ignored.
        Op = 3'b000; A = 32'd2; B = 32'd3; Start = 1'b1;
        @(negedge clk);
        Op = 3'b011; A = 32'h1234; We = 1'b1; HiLo = 1'b1;
        n = 0;
        while (busy0 === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
        Start = 1'b0; We = 1'b0;
        chk("ignore_busy_cycles", n, 5);
        check_out("ignore", 32'd0, 32'd6);
        repeat (4) @(negedge clk);

        // Start and We together while idle: the operation runs, the write is dropped.
        Op = 3'b000; A = 32'd3; B = 32'd4; Start = 1'b1; We = 1'b1; HiLo = 1'b0;
        @(negedge clk);
        Start = 1'b0; We = 1'b0;
        #1;
        chk("startwe_hi_unwritten", out0, 32'd0);
        chk("startwe_busy", busy0, 1'b1);
        n = 0;
        while (busy0 === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
        check_out("startwe", 32'd0, 32'd12);

        // mtlo.
        We = 1'b1; HiLo = 1'b1; A = 32'h0000_ABCD;
        @(negedge clk);
        We = 1'b0;
        #1;
        chk("mtlo", out0, 32'h0000_ABCD);

        // Reset in the third busy cycle of a div aborts without commit.
        run_op("div_pre", 3'b011, 32'd100, 32'd7, 10);
        Op = 3'b011; A = 32'd200; B = 32'd3; Start = 1'b1;
        @(negedge clk);
        Start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("abort_busy", busy0, 1'b0);
        check_out("abort", 32'd0, 32'd0);
        repeat (15) @(negedge clk);
        check_out("abort_late", 32'd0, 32'd0);

        // WIDTH=8, one-cycle multiply.
        Op = 3'b001; A = 32'h80; B = 32'h80; Start = 1'b1;
        @(negedge clk);
        Start = 1'b0;
        chk("w8_busy_first", busy1, 1'b1);
        @(negedge clk);
        chk("w8_busy_done", busy1, 1'b0);
        HiLo = 1'b0;
        #1;
        chk("w8_hi", out1, 8'h40);
        HiLo = 1'b1;
        #1;
        chk("w8_lo", out1, 8'h00);
        n = 0;
        while (busy0 === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end

        // Randomised traffic, including corner operands and occasional reset.
        repeat (3000) begin
            @(negedge clk);
            reset = ($urandom_range(0, 199) != 0);
            Start = ($urandom_range(0, 3) == 0);
            We    = ($urandom_range(0, 3) == 0);
            HiLo  = 1'($urandom_range(0, 1));
            Op    = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 7))
                0:       A = 32'h8000_0000;
                1:       A = 32'hFFFF_FFFF;
                2:       A = 32'h0000_0080;
                default: A = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0:       B = 32'h0;
                1:       B = 32'hFFFF_FFFF;
                2:       B = 32'h0000_00FF;
                3:       B = 32'h0000_0000 | 32'($urandom_range(0, 3));
                default: B = $urandom;
            endcase
        end
        @(negedge clk);
        reset = 1'b1; Start = 1'b0; We = 1'b0;
        repeat (12) @(negedge clk);
        chk_en = 1'b0;
        #5;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/md_unit.md
# md_unit

Parametrised multiply/divide unit with architectural HI/LO registers and a configurable-latency busy interlock. It sits in the EX stage beside the ALU and is driven by the decoded multiply/divide control fields (Start, HiLo, We, Op). It extends that control set with a 3-bit Op that adds multiply-accumulate and multiply-subtract (madd/maddu/msub/msubu). It owns HI/LO state, models iterative latency with a down-counter and exports Busy so the hazard unit can stall mf*/mt*/md instructions.

## Interface
- WIDTH, 32, operand and HI/LO width (>= 2)
- MULT_CYCLES, 5, busy cycles for mult/multu/madd/maddu/msub/msubu (>= 1)
- DIV_CYCLES, 10, busy cycles for div/divu (>= 1)
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-low; sampled on rising edge of clk
- Start  in  1  launch operation Op on A, B
- Op  in  3  000 multu, 001 mult, 010 divu, 011 div, 100 maddu, 101 madd, 110 msubu, 111 msub
- HiLo  in  1  0 selects HI, 1 selects LO (for We and Out)
- We  in  1  write A into HI or LO (mthi/mtlo)
- A  in  WIDTH  operand 1 / write data
- B  in  WIDTH  operand 2
- Busy  out  1  operation in flight
- Out  out  WIDTH  HiLo ? LO : HI (combinational from registers)

## Operation
- States: IDLE, RUN. Counter width ceil(log2(max(MULT_CYCLES,DIV_CYCLES)+1)).
- IDLE, Start=1: latch A, B, Op; load counter with latency for Op; go RUN. We in same cycle ignored (Start wins).
- IDLE, Start=0, We=1: HI or LO (per HiLo) <= A at that edge.
- RUN: counter decrements each edge; on the edge where counter is 1, commit result to HI/LO, go IDLE.
- RUN: Start and We ignored (no queueing); hazard unit must stall.
- Result computed from latched operands only; input changes during RUN have no effect.
- multu/mult: {HI,LO} <= A*B, 2*WIDTH product, unsigned/signed.
- maddu/madd: {HI,LO} <= {HI,LO} + A*B; msubu/msub: {HI,LO} <= {HI,LO} - A*B. Accumulator is the {HI,LO} value at commit; wraps modulo 2^(2*WIDTH). Signed variants sign-extend product.
- divu: LO <= A/B, HI <= A%B unsigned.
- div: quotient truncates toward zero, remainder takes sign of dividend.
- B=0 (div or divu): LO <= all ones, HI <= A.
- div with A = most-negative, B = -1: LO <= A (most-negative), HI <= 0.
- Out always reflects committed HI/LO; during RUN it shows pre-operation values.

## Timing
- Reset (reset=0 at an edge): HI=0, LO=0, Busy=0, state IDLE, counter 0; aborts any RUN, no commit.
- Start sampled at edge t0. Busy=1 from after t0 through the edge t0+N, with N = MULT_CYCLES or DIV_CYCLES. HI/LO update and Busy falls at edge t0+N.
- Busy high for exactly N cycles per operation.
- Back-to-back operations: Start in the first cycle Busy=0 is accepted (no dead cycle).
- mthi/mtlo latency: 1 edge; Out shows the new value in the following cycle.
- Out is combinational: a HiLo change is visible in the same cycle.

## Test plan
- Reset, then mult A=-3 (0xFFFFFFFD), B=7, WIDTH=32 -> Busy high 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- multu A=0xFFFFFFFF, B=2 -> HI=1, LO=0xFFFFFFFE. Then madd A=1, B=1 -> HI=1, LO=0xFFFFFFFF. Then msubu A=0xFFFFFFFF, B=1 -> HI=1, LO=0.
- div A=-7, B=2 -> after 10 Busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu A=5, B=0 -> LO=0xFFFFFFFF, HI=5. div 0x80000000/-1 -> LO=0x80000000, HI=0.
- During RUN of multu 2*3, assert We=1, HiLo=1, A=0x1234 and Start with Op=div -> both ignored; HI=0, LO=6, Busy falls after exactly 5 cycles.
- Idle with Start=1 and We=1 in the same cycle -> operation runs and write is dropped. Idle mtlo A=0xABCD -> Out(HiLo=1)=0xABCD next cycle.
- reset=0 on the 3rd Busy cycle of div -> next cycle Busy=0, HI=LO=0, and no later commit occurs. Repeat with WIDTH=8, MULT_CYCLES=1: mult 0x80*0x80 -> HI=0x40, LO=0x00, Busy high 1 cycle.
